// File: rtl/reg_access_bridge.sv
// -----------------------------------------------------------------------------
// reg_access_bridge
//
// Converts a valid/ready request/response handshake into single-cycle
// accesses on a simple downstream register port. The downstream port has a
// write strobe, an address and write data. Read data returns one cycle after
// the address is presented with reg_write low.
//
// Transaction flow (one request in flight at a time):
//   IDLE    -> WRITE   -> RESP                (write, response 2 cycles after accept)
//   IDLE    -> READ    -> CAPTURE -> RESP     (read,  response 3 cycles after accept)
//   IDLE    -> RESP                           (address error, see below)
//   RESP    -> IDLE    once rsp_ready is seen
//
// Optional feature (macro REG_BRIDGE_ADDR_CHECK_EN):
//   When the macro is defined, a request with req_addr >= NUM_REGS gets a
//   response with rsp_err=1 and rsp_rdata=0. That request causes no
//   downstream access.
//   When the macro is undefined, rsp_err is always 0 and every address is
//   forwarded downstream.
//
// Parameters:
//   ADDR_W   - request / register address width
//   DATA_W   - write / read data width
//   NUM_REGS - number of implemented downstream registers (0..NUM_REGS-1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   upstream request present
//   req_ready  out  bridge accepts a request this cycle (IDLE only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   target register address
//   req_wdata  in   write data
//   rsp_valid  out  response present
//   rsp_ready  in   upstream takes the response
//   rsp_rdata  out  read data (0 for writes and address errors)
//   rsp_err    out  address error flag
//   reg_write  out  downstream write strobe (0 = downstream read)
//   reg_addr   out  downstream register address
//   reg_wdata  out  downstream write data
//   reg_rdata  in   downstream read data, one cycle after the address
//   txn_count  out  completed responses, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module reg_access_bridge #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [15:0]       txn_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Saturating increment for the completed-response counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

`ifdef REG_BRIDGE_ADDR_CHECK_EN
    // NUM_REGS is held one bit wider than the address so that a register
    // count of exactly 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    // True when an address lies outside the implemented register range.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= NUM_REGS_W);
    endfunction
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;
    logic              addr_err_s;
    logic              rsp_done_s;

    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              reg_write_r;
    logic [ADDR_W-1:0] reg_addr_r;
    logic [DATA_W-1:0] reg_wdata_r;
    logic [15:0]       txn_count_r;
    logic [15:0]       txn_count_nxt_s;

    // Ready is gated by rst so that it reads 0 for the whole time reset is
    // held. It reads 1 in the first cycle after rst drops, because the reset
    // edges have already parked the FSM in IDLE.
    assign req_ready  = (state_r == ST_IDLE) && !rst;
    assign accept_s   = req_valid && req_ready;
    assign rsp_done_s = rsp_valid_r && rsp_ready;

`ifdef REG_BRIDGE_ADDR_CHECK_EN
    assign addr_err_s = addr_out_of_range(req_addr);
`else
    assign addr_err_s = 1'b0;
`endif

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (addr_err_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (req_write) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE:   state_nxt_s = ST_RESP;
            ST_READ:    state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Completed-response counter next value (holds at all-ones).
    always_comb begin
        txn_count_nxt_s = txn_count_r;
        if (rsp_done_s) begin
            txn_count_nxt_s = sat_inc16(txn_count_r);
        end else begin
            txn_count_nxt_s = txn_count_r;
        end
    end

    // Registered outputs: downstream port, response payload and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            reg_write_r <= 1'b0;
            reg_addr_r  <= {ADDR_W{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            txn_count_r <= 16'd0;
        end else begin
            // These flags follow the next state, so each one is high exactly
            // while the FSM sits in WRITE or in RESP.
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            reg_write_r <= (state_nxt_s == ST_WRITE);
            txn_count_r <= txn_count_nxt_s;

            // The downstream address and data change only when a forwarded
            // request is accepted. They hold in every other cycle, and a
            // rejected (out-of-range) request leaves them unchanged.
            if (accept_s && !addr_err_s) begin
                reg_addr_r  <= req_addr;
                reg_wdata_r <= req_wdata;
            end else begin
                reg_addr_r  <= reg_addr_r;
                reg_wdata_r <= reg_wdata_r;
            end

            // Response data is cleared at accept, which covers writes and
            // address errors. Reads then overwrite it at the end of CAPTURE,
            // when downstream data is valid.
            if (accept_s) begin
                rsp_rdata_r <= {DATA_W{1'b0}};
                rsp_err_r   <= addr_err_s;
            end else if (state_r == ST_CAPTURE) begin
                rsp_rdata_r <= reg_rdata;
                rsp_err_r   <= rsp_err_r;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
`ifdef REG_BRIDGE_ADDR_CHECK_EN
    assign rsp_err   = rsp_err_r;
`else
    assign rsp_err   = 1'b0;
`endif
    assign reg_write = reg_write_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign txn_count = txn_count_r;

endmodule
